// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, fetch/hold FSM and the IF/ID
// pipeline register feeding decode. Branch and jump redirects, flush
// bubbles and hazard stalls are resolved here each cycle.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        flush,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump,
    input  logic [25:0] jump_index,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ready,
    output logic [31:0] inst,
    output logic [31:0] pc_plus4,
    output logic        valid
);

    typedef enum logic {
        FETCH = 1'b0,
        HOLD  = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] inst_q, inst_d;
    logic [31:0] pc_plus4_q, pc_plus4_d;
    logic        valid_q, valid_d;
    logic [31:0] hold_q, hold_d;

    logic [31:0] pc_inc;
    logic [31:0] branch_pc;
    logic [31:0] jump_pc;

    // Redirect targets and the sequential PC; the increment wraps naturally
    // at 32 bits, and the low two address bits are always forced to zero.
    always_comb begin
        pc_inc    = pc_q + 32'd4;
        branch_pc = branch_target & ~32'd3;
        jump_pc   = {pc_plus4_q[31:28], jump_index, 2'b00};
    end

    // Next-state logic: branch beats jump beats flush beats stall.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        inst_d     = inst_q;
        pc_plus4_d = pc_plus4_q;
        valid_d    = valid_q;
        hold_d     = hold_q;

        if (branch_taken) begin
            // Any word in flight or parked in the hold buffer is dropped.
            pc_d    = branch_pc;
            valid_d = 1'b0;
            state_d = FETCH;
        end else if (jump) begin
            pc_d    = jump_pc;
            valid_d = 1'b0;
            state_d = FETCH;
        end else begin
            case (state_q)
                FETCH: begin
                    if (imem_ready) begin
                        if (stall) begin
                            // Decode cannot accept yet; park the word.
                            hold_d  = imem_rdata;
                            state_d = HOLD;
                        end else begin
                            inst_d     = imem_rdata;
                            pc_plus4_d = pc_inc;
                            valid_d    = 1'b1;
                            pc_d       = pc_inc;
                        end
                    end else if (!stall) begin
                        // Memory not ready: hand decode a bubble.
                        valid_d = 1'b0;
                    end
                end
                HOLD: begin
                    if (!stall) begin
                        inst_d     = hold_q;
                        pc_plus4_d = pc_inc;
                        valid_d    = 1'b1;
                        pc_d       = pc_inc;
                        state_d    = FETCH;
                    end
                end
                default: state_d = FETCH;
            endcase
            // Flush keeps the PC/state progression but marks IF/ID empty.
            if (flush) begin
                valid_d = 1'b0;
            end
        end
    end

    // State and IF/ID registers; reset takes effect without waiting for clk.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= FETCH;
            pc_q       <= RESET_PC;
            inst_q     <= 32'h0;
            pc_plus4_q <= 32'h0;
            valid_q    <= 1'b0;
            hold_q     <= 32'h0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            inst_q     <= inst_d;
            pc_plus4_q <= pc_plus4_d;
            valid_q    <= valid_d;
            hold_q     <= hold_d;
        end
    end

    // Outputs; no request is issued while reset is held.
    always_comb begin
        imem_req  = (state_q == FETCH) && !rst;
        imem_addr = pc_q;
        inst      = inst_q;
        pc_plus4  = pc_plus4_q;
        valid     = valid_q;
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a combinational instruction memory.
module tb_fetch_stage;

    logic        clk;
    logic        rst, stall, flush, branch_taken, jump, imem_ready;
    logic [31:0] branch_target;
    logic [25:0] jump_index;
    logic        imem_req;
    logic [31:0] imem_addr, imem_rdata, inst, pc_plus4;
    logic        valid;

    logic        rst2, zero1, ready2;
    logic [31:0] zero32;
    logic [25:0] zero26;
    logic        imem_req2, valid2;
    logic [31:0] imem_addr2, imem_rdata2, inst2, pc_plus4_2;

    int checks = 0;
    int failures = 0;

    fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .jump(jump), .jump_index(jump_index),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rdata(imem_rdata), .imem_ready(imem_ready),
        .inst(inst), .pc_plus4(pc_plus4), .valid(valid)
    );

    fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
        .clk(clk), .rst(rst2), .stall(zero1), .flush(zero1),
        .branch_taken(zero1), .branch_target(zero32),
        .jump(zero1), .jump_index(zero26),
        .imem_req(imem_req2), .imem_addr(imem_addr2),
        .imem_rdata(imem_rdata2), .imem_ready(ready2),
        .inst(inst2), .pc_plus4(pc_plus4_2), .valid(valid2)
    );

    function automatic logic [31:0] mem(input logic [31:0] a);
        case (a)
            32'h0: return 32'h2008_0001;
            32'h4: return 32'h2009_0002;
            32'h8: return 32'h200A_0003;
            32'hC: return 32'h200B_0004;
            default: return {16'hC0DE, a[15:0]};
        endcase
    endfunction

    always_comb imem_rdata  = mem(imem_addr);
    always_comb imem_rdata2 = mem(imem_addr2);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; flush = 1'b0; branch_taken = 1'b0; jump = 1'b0;
        imem_ready = 1'b1; branch_target = 32'h0; jump_index = 26'h0;
        rst2 = 1'b1; zero1 = 1'b0; ready2 = 1'b1; zero32 = 32'h0; zero26 = 26'h0;

        // Reset state
        tick();
        chk("rst_req", {31'b0, imem_req}, 32'h0);
        chk("rst_inst", inst, 32'h0);
        chk("rst_pc4", pc_plus4, 32'h0);
        chk("rst_valid", {31'b0, valid}, 32'h0);
        chk("rst_addr", imem_addr, 32'h0);
        chk("rst2_addr", imem_addr2, 32'hFFFF_FFFC);
        rst = 1'b0;
        #1;
        chk("rel_req", {31'b0, imem_req}, 32'h1);
        chk("rel_addr", imem_addr, 32'h0);

        // Sequential fetch from 0x0, 0x4
        tick();
        chk("f0_inst", inst, 32'h2008_0001);
        chk("f0_pc4", pc_plus4, 32'h4);
        chk("f0_valid", {31'b0, valid}, 32'h1);
        tick();
        chk("f1_inst", inst, 32'h2009_0002);
        chk("f1_pc4", pc_plus4, 32'h8);
        chk("f1_addr", imem_addr, 32'h8);

        // Three-cycle stall at PC=0x8
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("st_inst", inst, 32'h2009_0002);
            chk("st_req", {31'b0, imem_req}, 32'h0);
            chk("st_addr", imem_addr, 32'h8);
        end
        stall = 1'b0;
        tick();
        chk("st_rel_inst", inst, 32'h200A_0003);
        chk("st_rel_pc4", pc_plus4, 32'hC);
        chk("st_rel_addr", imem_addr, 32'hC);
        chk("st_rel_req", {31'b0, imem_req}, 32'h1);

        // Branch overrides stall and discards the hold buffer
        stall = 1'b1;
        tick();
        chk("hold_req", {31'b0, imem_req}, 32'h0);
        branch_taken = 1'b1; branch_target = 32'h0000_0043;
        tick();
        chk("br_addr", imem_addr, 32'h40);
        chk("br_valid", {31'b0, valid}, 32'h0);
        chk("br_req", {31'b0, imem_req}, 32'h1);
        branch_taken = 1'b0; stall = 1'b0;
        tick();
        chk("br_inst", inst, 32'hC0DE_0040);
        chk("br_pc4", pc_plus4, 32'h44);

        // Set up pc_plus4 = 0x1000_0010
        branch_taken = 1'b1; branch_target = 32'h1000_000C;
        tick();
        branch_taken = 1'b0;
        tick();
        chk("pre_j_pc4", pc_plus4, 32'h1000_0010);

        // Branch beats jump, then jump alone
        branch_taken = 1'b1; branch_target = 32'h0000_0200;
        jump = 1'b1; jump_index = 26'h000_0100;
        tick();
        chk("bj_addr", imem_addr, 32'h200);
        chk("bj_valid", {31'b0, valid}, 32'h0);
        branch_taken = 1'b0;
        tick();
        chk("j_addr", imem_addr, 32'h1000_0400);
        chk("j_valid", {31'b0, valid}, 32'h0);
        jump = 1'b0;
        tick();
        chk("j_inst", inst, 32'hC0DE_0400);
        chk("j_pc4", pc_plus4, 32'h1000_0404);

        // Two not-ready cycles produce bubbles
        imem_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("nr_valid", {31'b0, valid}, 32'h0);
            chk("nr_addr", imem_addr, 32'h1000_0404);
            chk("nr_inst", inst, 32'hC0DE_0400);
        end
        imem_ready = 1'b1;

        // Flush: word consumed, PC advances, IF/ID marked empty
        flush = 1'b1;
        tick();
        chk("fl_valid", {31'b0, valid}, 32'h0);
        chk("fl_addr", imem_addr, 32'h1000_0408);
        flush = 1'b0;

        // Asynchronous reset in the middle of HOLD
        stall = 1'b1;
        tick();
        chk("ar_hold_req", {31'b0, imem_req}, 32'h0);
        #2 rst = 1'b1;
        #1;
        chk("ar_req", {31'b0, imem_req}, 32'h0);
        chk("ar_addr", imem_addr, 32'h0);
        chk("ar_inst", inst, 32'h0);
        chk("ar_pc4", pc_plus4, 32'h0);
        chk("ar_valid", {31'b0, valid}, 32'h0);
        #1 rst = 1'b0; stall = 1'b0;
        tick();
        chk("ar_fetch_inst", inst, 32'h2008_0001);
        chk("ar_fetch_pc4", pc_plus4, 32'h4);

        // PC wrap from 0xFFFF_FFFC
        rst2 = 1'b0;
        #1;
        chk("wr_req", {31'b0, imem_req2}, 32'h1);
        tick();
        chk("wr_inst", inst2, 32'hC0DE_FFFC);
        chk("wr_pc4", pc_plus4_2, 32'h0);
        chk("wr_addr", imem_addr2, 32'h0);
        chk("wr_valid", {31'b0, valid2}, 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
